score_keeper: RTL
=================

Name: score_keeper

Overview:
- Downstream of the game logic block: consumes single-cycle point events (ball passed a paddle) and keeps the match score for Player A and Player B.
- Scores are held as 2-digit BCD, table-tennis rules apply (win at WIN_SCORE, win by 2), serve side is tracked, and the rally is frozen for a pause after each point.
- Drives four active-low 7-segment digits on the board and returns play_en and serve_a to the game logic.

Parameters:
- WIN_SCORE, 11, points needed to win (2..98).
- PAUSE_CYCLES, 25000000, pixel_clk cycles of freeze after each point (1 s at 25 MHz); minimum 1.

Ports:
- pixel_clk  input  1  25 MHz pixel clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- point_a  input  1  one-cycle pulse: Player A scored.
- point_b  input  1  one-cycle pulse: Player B scored.
- new_game  input  1  one-cycle pulse (debounced button): restart the match.
- score_a  output  8  Player A score, BCD {tens, ones}.
- score_b  output  8  Player B score, BCD {tens, ones}.
- hex_a1, hex_a0, hex_b1, hex_b0  output  7 each  active-low segments {g..a} for the tens/ones digits; tens digit is blanked (7'h7F) when it is 0.
- play_en  output  1  1 = ball may move; 0 = game logic holds the ball at the serve position.
- serve_a  output  1  1 = Player A serves.
- game_over  output  1  match finished.
- winner_a  output  1  valid while game_over: 1 = A won, 0 = B won.

Behaviour:
- Reset (async assert, sync release), all registered outputs: score_a = score_b = 8'h00, state PLAY, play_en = 1, serve_a = 1, game_over = 0, winner_a = 0, pause counter = 0.
- States:
  - PLAY: play_en = 1.
  - PAUSE: play_en = 0, counter running.
  - OVER: play_en = 0, game_over = 1.
- PLAY, exactly one of point_a/point_b high: increment that player's BCD score (ones 9 -> 0 carries into tens), update serve, go to PAUSE with counter = 0. Score outputs show the new value on the next cycle.
- PLAY, point_a and point_b high in the same cycle: both ignored; no state or score change.
- PAUSE: counter increments every cycle. When counter = PAUSE_CYCLES-1, go to PLAY. point inputs are ignored in PAUSE.
- Win check uses the updated scores in the same cycle as the increment. If the scorer reaches ≥ WIN_SCORE and leads by ≥ 2, go to OVER instead of PAUSE, set winner_a accordingly, and hold the scores.
- Saturation: if a score would reach 99, it is set to 99 and that player wins immediately (sudden death).
- Serve:
  - serve_a toggles after every 2nd total point, i.e. when (A+B) becomes even.
  - Once both scores are ≥ WIN_SCORE-1, serve_a toggles on every point.
  - serve_a is computed from the updated total.
- OVER: all point inputs ignored; stays until new_game.
- new_game (any state, highest priority over points): next cycle scores = 0, serve_a = 1, game_over = 0, state PLAY. The pause counter is cleared.
- Reset asserted mid-pause or mid-increment: immediate return to the reset values.
- Segment decode is combinational from the score registers (same-cycle as the score outputs).
- Score arithmetic is BCD only; no binary score registers. The lead comparison is done on BCD values, converting as tens×10+ones in 7 bits.

Decomposition:
- Shared package/header holds:
  - state encodings ST_PLAY, ST_PAUSE, ST_OVER;
  - segment constants SEG_BLANK = 7'h7F and SEG_0..SEG_9;
  - the BCD-increment function.
- One sub-module is natural: seg7_decoder (4-bit BCD in, blank_zero flag in, 7-bit active-low segments out), instantiated four times.

Test Plan:
- Reset, then 3 point_a pulses separated by pauses (PAUSE_CYCLES=4) → score_a=8'h03, score_b=8'h00. play_en low for exactly 4 cycles after each point. serve_a reads 1,0,0 after points 1,2,3. hex_a0=SEG_3, hex_a1=7'h7F.
- A reaches 9 → next point gives score_a=8'h10, hex_a1=SEG_1, hex_a0=SEG_0.
- Deuce: bring the score to 10–10, then A, B, A, A → no game_over at 11–10 or 11–11. At 13–11: game_over=1, winner_a=1, play_en=0. serve_a toggles on each of these points.
- point_a and point_b in the same PLAY cycle → scores unchanged, state stays PLAY. A point_a pulse during PAUSE → ignored.
- In OVER, point_b pulse → no change. Then new_game → next cycle scores 8'h00, serve_a=1, game_over=0, play_en=1.
- Assert reset mid-PAUSE at score 5–4 → all outputs return to reset values immediately (asynchronously), and play_en=1 after release.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types, segment patterns and BCD helpers for the score keeper.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package score_keeper_pkg;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_PAUSE = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Two-digit BCD increment, saturating at 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v >= 8'h99)
         return 8'h99;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // BCD to binary for the lead comparison (max 99 fits 7 bits).
   function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
      return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
   endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Point events in, score/display/serve status out.
// master = game logic side, slave = score keeper.
interface score_keeper_if;

   logic       point_a;
   logic       point_b;
   logic       new_game;
   logic [7:0] score_a;
   logic [7:0] score_b;
   logic [6:0] hex_a1;
   logic [6:0] hex_a0;
   logic [6:0] hex_b1;
   logic [6:0] hex_b0;
   logic       play_en;
   logic       serve_a;
   logic       game_over;
   logic       winner_a;

   modport master (
      output point_a, point_b, new_game,
      input  score_a, score_b,
      input  hex_a1, hex_a0, hex_b1, hex_b0,
      input  play_en, serve_a, game_over, winner_a
   );

   modport slave (
      input  point_a, point_b, new_game,
      output score_a, score_b,
      output hex_a1, hex_a0, hex_b1, hex_b0,
      output play_en, serve_a, game_over, winner_a
   );

endinterface

// File: rtl/score_keeper_seg7.sv
// BCD digit to active-low 7-segment pattern.
// Zero is blanked when blank_zero is set; non-BCD codes blank.
module seg7_decoder
   import score_keeper_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank_zero,
   output logic [6:0] seg
);

   // Pure lookup from digit to segment pattern.
   always_comb begin
      seg = SEG_BLANK;
      unique case (digit)
         4'd0: seg = blank_zero ? SEG_BLANK : SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_keeper.sv
// Match score keeper: BCD scores, win-by-two, serve tracking,
// post-point freeze and four 7-segment digit drivers.
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int WIN_SCORE    = 11,
   parameter int PAUSE_CYCLES = 25000000
) (
   input  logic pixel_clk,
   input  logic reset,
   score_keeper_if.slave sk
);

   localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PAUSE_CYCLES - 1);
   localparam logic [6:0] WIN  = 7'(WIN_SCORE);
   localparam logic [6:0] DEUCE = 7'(WIN_SCORE - 1);

   state_t        state, state_n;
   logic [7:0]    sa, sa_n, sb, sb_n;
   logic          srv, srv_n;
   logic          win, win_n;
   logic [CW-1:0] cnt, cnt_n;

   logic          pa, pb;
   logic [7:0]    nsa, nsb;
   logic [6:0]    na, nb;
   logic          won, flip;

   logic [6:0]    seg_a1, seg_a0, seg_b1, seg_b0;

   // State, scores, serve, winner and pause counter registers.
   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         state <= ST_PLAY;
         sa    <= 8'h00;
         sb    <= 8'h00;
         srv   <= 1'b1;
         win   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sa    <= sa_n;
         sb    <= sb_n;
         srv   <= srv_n;
         win   <= win_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic; win and serve use the post-increment scores.
   always_comb begin
      state_n = state;
      sa_n    = sa;
      sb_n    = sb;
      srv_n   = srv;
      win_n   = win;
      cnt_n   = cnt;

      pa   = sk.point_a & ~sk.point_b;
      pb   = sk.point_b & ~sk.point_a;
      nsa  = pa ? bcd_inc(sa) : sa;
      nsb  = pb ? bcd_inc(sb) : sb;
      na   = bcd_to_bin(nsa);
      nb   = bcd_to_bin(nsb);
      won  = pa ? (nsa == 8'h99 || (na >= WIN && na >= nb + 7'd2))
                : (nsb == 8'h99 || (nb >= WIN && nb >= na + 7'd2));
      flip = ~(na[0] ^ nb[0]) | (na >= DEUCE && nb >= DEUCE);

      if (sk.new_game) begin
         state_n = ST_PLAY;
         sa_n    = 8'h00;
         sb_n    = 8'h00;
         srv_n   = 1'b1;
         win_n   = 1'b0;
         cnt_n   = '0;
      end else begin
         unique case (state)
            ST_PLAY: begin
               if (pa | pb) begin
                  sa_n  = nsa;
                  sb_n  = nsb;
                  cnt_n = '0;
                  if (flip)
                     srv_n = ~srv;
                  if (won) begin
                     state_n = ST_OVER;
                     win_n   = pa;
                  end else begin
                     state_n = ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (cnt == CNT_LAST) begin
                  state_n = ST_PLAY;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_OVER: begin
               state_n = ST_OVER;
            end
            default: state_n = ST_PLAY;
         endcase
      end
   end

   seg7_decoder u_a1 (.digit(sa[7:4]), .blank_zero(1'b1), .seg(seg_a1));
   seg7_decoder u_a0 (.digit(sa[3:0]), .blank_zero(1'b0), .seg(seg_a0));
   seg7_decoder u_b1 (.digit(sb[7:4]), .blank_zero(1'b1), .seg(seg_b1));
   seg7_decoder u_b0 (.digit(sb[3:0]), .blank_zero(1'b0), .seg(seg_b0));

   assign sk.score_a   = sa;
   assign sk.score_b   = sb;
   assign sk.hex_a1    = seg_a1;
   assign sk.hex_a0    = seg_a0;
   assign sk.hex_b1    = seg_b1;
   assign sk.hex_b0    = seg_b0;
   assign sk.play_en   = (state == ST_PLAY);
   assign sk.game_over = (state == ST_OVER);
   assign sk.serve_a   = srv;
   assign sk.winner_a  = win;

endmodule
